pe_mac_ctrl: RTL and testbench

// Job sequencer for one pipelined PE (pe_core: 3-stage mult/acc/relu, 4-cycle enable-to-results).

---
 rtl/pe_pkg.sv | 15 +
 rtl/pe_mac_ctrl.sv | 119 +++++++++++
 tb/tb_pe_mac_ctrl.sv | 265 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/pe_pkg.sv
// Shared definitions for the processing-element slice: controller states and
// the PE pipeline depth that both pe_core and pe_mac_ctrl must agree on.
package pe_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    STREAM,
    DRAIN,
    HOLD
  } pe_ctrl_state_t;

  localparam int PE_PIPE_LAT = 4;

endpackage

// File: rtl/pe_mac_ctrl.sv
// Dot-product job sequencer for one pipelined PE: clears the accumulator, streams
// K operand pairs, waits out the PE pipeline and holds the final result for the consumer.
module pe_mac_ctrl
  import pe_pkg::*;
#(
  parameter int W_IN     = 8,
  parameter int W_ACC    = 24,
  parameter int W_LEN    = 10,
  parameter int PIPE_LAT = PE_PIPE_LAT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [W_LEN-1:0] cmd_len,
  input  logic             cmd_relu,
  input  logic             op_valid,
  output logic             op_ready,
  input  logic [W_IN-1:0]  op_a,
  input  logic [W_IN-1:0]  op_b,
  output logic             pe_en,
  output logic             pe_reg_reset,
  output logic             pe_mode_sel,
  output logic [W_IN-1:0]  pe_a_mul,
  output logic [W_IN-1:0]  pe_b_mul,
  input  logic [W_ACC-1:0] pe_results,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [W_ACC-1:0] res_data,
  output logic             busy
);

  localparam int                  DRAIN_W    = $clog2(PIPE_LAT + 1);
  localparam logic [DRAIN_W-1:0]  DRAIN_LAST = DRAIN_W'(PIPE_LAT - 1);

  pe_ctrl_state_t     state_q, state_d;
  logic [W_LEN-1:0]   rem_q, rem_d;
  logic [DRAIN_W-1:0] drain_q, drain_d;
  logic               mode_q, mode_d;
  logic               zero_q, zero_d;
  logic [W_ACC-1:0]   res_q, res_d;

  // NOTE: every variable gets its hold value first so no path through the case infers a latch.
  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    drain_d = drain_q;
    mode_d  = mode_q;
    zero_d  = zero_q;
    res_d   = res_q;
    unique case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          state_d = CLEAR;
          rem_d   = cmd_len;
          mode_d  = cmd_relu;
          zero_d  = (cmd_len == '0);
        end
      end
      CLEAR: begin
        drain_d = DRAIN_LAST;
        state_d = zero_q ? DRAIN : STREAM;
      end
      STREAM: begin
        if (op_valid) begin
          rem_d = rem_q - W_LEN'(1);
          if (rem_q == W_LEN'(1)) begin
            state_d = DRAIN;
            drain_d = DRAIN_LAST;
          end
        end
      end
      DRAIN: begin
        // Only the value present in the final drain cycle is the completed dot product.
        if (drain_q == '0) begin
          res_d   = zero_q ? '0 : pe_results;
          state_d = HOLD;
        end else begin
          drain_d = drain_q - DRAIN_W'(1);
        end
      end
      HOLD: begin
        if (res_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state_q <= IDLE;
      rem_q   <= '0;
      drain_q <= '0;
      mode_q  <= 1'b0;
      zero_q  <= 1'b0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      drain_q <= drain_d;
      mode_q  <= mode_d;
      zero_q  <= zero_d;
      res_q   <= res_d;
    end
  end

  assign cmd_ready    = (state_q == IDLE);
  assign op_ready     = (state_q == STREAM);
  assign pe_en        = op_valid & op_ready;
  assign pe_reg_reset = (state_q == CLEAR);
  assign pe_mode_sel  = mode_q;
  assign pe_a_mul     = op_a;
  assign pe_b_mul     = op_b;
  assign res_valid    = (state_q == HOLD);
  assign res_data     = res_q;
  assign busy         = (state_q != IDLE);

endmodule

// File: tb/tb_pe_mac_ctrl.sv
// Bench for pe_mac_ctrl with a 4-deep behavioural PE and a result scoreboard.
// Note: rst_n is asserted high (asynchronous, active-high) in this codebase.
module tb_pe_mac_ctrl;
  import pe_pkg::*;

  localparam int W_IN  = 8;
  localparam int W_ACC = 24;
  localparam int W_LEN = 10;

  logic             clk = 1'b0;
  logic             rst_n = 1'b1;
  logic             cmd_valid = 1'b0;
  logic             cmd_ready;
  logic [W_LEN-1:0] cmd_len = '0;
  logic             cmd_relu = 1'b0;
  logic             op_valid = 1'b0;
  logic             op_ready;
  logic [W_IN-1:0]  op_a = '0;
  logic [W_IN-1:0]  op_b = '0;
  logic             pe_en;
  logic             pe_reg_reset;
  logic             pe_mode_sel;
  logic [W_IN-1:0]  pe_a_mul;
  logic [W_IN-1:0]  pe_b_mul;
  logic [W_ACC-1:0] pe_results;
  logic             res_valid;
  logic             res_ready = 1'b0;
  logic [W_ACC-1:0] res_data;
  logic             busy;

  pe_mac_ctrl #(
    .W_IN(W_IN), .W_ACC(W_ACC), .W_LEN(W_LEN), .PIPE_LAT(PE_PIPE_LAT)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_len(cmd_len), .cmd_relu(cmd_relu),
    .op_valid(op_valid), .op_ready(op_ready), .op_a(op_a), .op_b(op_b),
    .pe_en(pe_en), .pe_reg_reset(pe_reg_reset), .pe_mode_sel(pe_mode_sel),
    .pe_a_mul(pe_a_mul), .pe_b_mul(pe_b_mul), .pe_results(pe_results),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .busy(busy)
  );

  always #5 clk = ~clk;

  // Behavioural pe_core: product reg, accumulator, relu stage, output reg (4 cycles).
  logic signed [16:0] p1_q;
  logic               v1_q;
  logic [W_ACC-1:0]   acc_q, relu_q, out_q;
  always @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      p1_q <= '0; v1_q <= 1'b0; acc_q <= '0; relu_q <= '0; out_q <= '0;
    end else begin
      v1_q <= pe_en;
      if (pe_en) p1_q <= $signed({1'b0, pe_a_mul}) * $signed(pe_b_mul);
      if (pe_reg_reset) acc_q <= '0;
      else if (v1_q)    acc_q <= acc_q + {{7{p1_q[16]}}, p1_q};
      relu_q <= (pe_mode_sel && acc_q[W_ACC-1]) ? '0 : acc_q;
      out_q  <= relu_q;
    end
  end
  assign pe_results = out_q;

  int cyc = 0;
  int en_cnt = 0;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) if (pe_en) en_cnt <= en_cnt + 1;

  logic [W_ACC-1:0] exp_q[$];
  int ja[8];
  int jb[8];
  int n_assert = 0;
  int n_fail = 0;

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  function automatic logic [W_ACC-1:0] model(int k, bit relu);
    int sum = 0;
    logic [W_ACC-1:0] r;
    for (int i = 0; i < k; i++) sum += ja[i] * jb[i];
    r = W_ACC'(sum);
    if (relu && r[W_ACC-1]) r = '0;
    return r;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic start_cmd(input int k, input bit relu, output int c, output int e0);
    n_assert++;
    if (cmd_ready !== 1'b1) begin
      n_fail++; $display("FAIL cmd_ready_idle: got %b want 1", cmd_ready);
    end
    cmd_len = W_LEN'(k); cmd_relu = relu; cmd_valid = 1'b1;
    c = cyc; e0 = en_cnt;
    exp_q.push_back(model(k, relu));
    step();
    cmd_valid = 1'b0;
    n_assert++;
    if (pe_reg_reset !== 1'b1 || pe_mode_sel !== relu || pe_en !== 1'b0) begin
      n_fail++;
      $display("FAIL clear_cycle: reg_reset=%b mode=%b en=%b want 1 %b 0",
               pe_reg_reset, pe_mode_sel, pe_en, relu);
    end
  endtask

  task automatic stream(input int k, input int bubbles);
    for (int i = 0; i < k; i++) begin
      int t;
      op_a = W_IN'(ja[i]); op_b = W_IN'(jb[i]); op_valid = 1'b1;
      t = 0;
      while (!op_ready && t < 20) begin step(); t++; end
      n_assert++;
      if (op_ready !== 1'b1) begin
        n_fail++; $display("FAIL stream_ready pair %0d: got %b want 1", i, op_ready);
      end
      step();
      op_valid = 1'b0;
      if (i < k - 1) repeat (bubbles) step();
    end
  endtask

  task automatic finish_job(input int k, input bit relu, input int c, input int e0,
                            input int bubbles, input int hold, input bit b2b);
    int t;
    int exp_lat;
    logic [W_ACC-1:0] exp_v;
    logic [W_ACC-1:0] held;
    t = 0;
    while (!res_valid && t < 100) begin step(); t++; end
    n_assert++;
    if (res_valid !== 1'b1) begin
      n_fail++; $display("FAIL res_valid_wait: got %b want 1", res_valid);
    end
    exp_lat = k + 6 + ((k > 0) ? (k - 1) * bubbles : 0);
    n_assert++;
    if (cyc - c != exp_lat) begin
      n_fail++; $display("FAIL latency K=%0d: got %0d want %0d", k, cyc - c, exp_lat);
    end
    n_assert++;
    if (exp_q.size() == 0) begin
      n_fail++; $display("FAIL scoreboard_empty: got 0 entries want 1");
    end else begin
      exp_v = exp_q.pop_front();
      if (res_data !== exp_v) begin
        n_fail++; $display("FAIL res_data K=%0d: got %h want %h", k, res_data, exp_v);
      end
    end
    n_assert++;
    if (en_cnt - e0 != k) begin
      n_fail++; $display("FAIL pe_en_count: got %0d want %0d", en_cnt - e0, k);
    end
    held = res_data;
    for (int h = 0; h < hold; h++) begin
      if (b2b) begin cmd_valid = 1'b1; cmd_len = W_LEN'(1); end
      step();
      n_assert++;
      if (cmd_ready !== 1'b0 || res_valid !== 1'b1 || res_data !== held || pe_mode_sel !== relu) begin
        n_fail++;
        $display("FAIL hold_stable cyc %0d: ready=%b valid=%b data=%h mode=%b want 0 1 %h %b",
                 h, cmd_ready, res_valid, res_data, pe_mode_sel, held, relu);
      end
    end
    res_ready = 1'b1;
    step();
    res_ready = 1'b0;
    cmd_valid = 1'b0;
    n_assert++;
    if (res_valid !== 1'b0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL res_release: valid=%b busy=%b want 0 0", res_valid, busy);
    end
  endtask

  task automatic run_job(input int k, input bit relu, input int bubbles,
                         input int hold, input bit b2b);
    int c;
    int e0;
    start_cmd(k, relu, c, e0);
    stream(k, bubbles);
    finish_job(k, relu, c, e0, bubbles, hold, b2b);
  endtask

  task automatic check_reset_outputs(input string tag);
    n_assert++;
    if (cmd_ready !== 1'b1 || op_ready !== 1'b0 || pe_en !== 1'b0 || pe_reg_reset !== 1'b0 ||
        pe_mode_sel !== 1'b0 || res_valid !== 1'b0 || res_data !== '0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL %s: cmd_rdy=%b op_rdy=%b en=%b clr=%b mode=%b rv=%b rd=%h busy=%b want 1 0 0 0 0 0 0 0",
               tag, cmd_ready, op_ready, pe_en, pe_reg_reset, pe_mode_sel, res_valid, res_data, busy);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    repeat (3) step();
    check_reset_outputs("reset_state");
    rst_n = 1'b0;
    step();
    check_reset_outputs("post_reset_idle");
  endtask

  task automatic test_basic();
    for (int i = 0; i < 3; i++) begin ja[i] = i + 1; jb[i] = i + 4; end
    run_job(3, 1'b0, 0, 2, 1'b0);
  endtask

  task automatic test_negative();
    for (int i = 0; i < 3; i++) begin ja[i] = i + 1; jb[i] = -(i + 4); end
    run_job(3, 1'b0, 0, 1, 1'b0);
    run_job(3, 1'b1, 0, 1, 1'b0);
  endtask

  task automatic test_bubbles();
    for (int i = 0; i < 4; i++) begin ja[i] = 255; jb[i] = -128; end
    run_job(4, 1'b0, 2, 1, 1'b0);
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 3; i++) begin ja[i] = i + 1; jb[i] = i + 4; end
    run_job(3, 1'b0, 0, 10, 1'b1);
    ja[0] = 2; jb[0] = 3;
    run_job(1, 1'b0, 0, 1, 1'b0);
  endtask

  task automatic test_zero_len();
    run_job(0, 1'b0, 0, 2, 1'b0);
  endtask

  task automatic test_reset_abort();
    int c;
    int e0;
    for (int i = 0; i < 5; i++) begin ja[i] = 7; jb[i] = 9; end
    start_cmd(5, 1'b1, c, e0);
    stream(2, 0);
    op_a = 8'd7; op_b = 8'd9; op_valid = 1'b1;
    rst_n = 1'b1;
    #2;
    check_reset_outputs("abort_async_reset");
    exp_q.delete();
    op_valid = 1'b0;
    step();
    rst_n = 1'b0;
    step();
    check_reset_outputs("abort_released");
    ja[0] = 1; ja[1] = 1; jb[0] = 1; jb[1] = 1;
    run_job(2, 1'b0, 0, 1, 1'b0);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_negative();
    test_bubbles();
    test_back_to_back();
    test_zero_len();
    test_reset_abort();
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
